// File: rtl/sha_hash_ctrl.sv
// rtl/sha_hash_ctrl.sv - register front-end and sequencer for an external SHA hash core
// Holds the message block, issues init/next pulses, captures the digest and reports status.
module sha_hash_ctrl #(
  parameter int BUS_WIDTH      = 64,
  parameter int BLOCK_WORDS    = 16,
  parameter int DIGEST_WORDS   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [7:0]                reglk_ctrl_i,
  input  logic                      acct_ctrl_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [7:0]                addr_i,
  input  logic [BUS_WIDTH-1:0]      wdata_i,
  output logic [BUS_WIDTH-1:0]      rdata_o,
  output logic                      core_init_o,
  output logic                      core_next_o,
  output logic [32*BLOCK_WORDS-1:0] core_block_o,
  input  logic                      core_ready_i,
  input  logic                      core_digest_valid_i,
  input  logic [32*DIGEST_WORDS-1:0] core_digest_i,
  output logic                      irq_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] IDX_CTRL   = 5'd0;
  localparam logic [4:0] IDX_STATUS = 5'd17;
  localparam logic [4:0] DATA_LAST  = 5'(BLOCK_WORDS);
  localparam logic [4:0] DIG_FIRST  = 5'd18;
  localparam logic [4:0] DIG_LAST   = 5'(17 + DIGEST_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q;
  logic [31:0]       data_q   [BLOCK_WORDS];
  logic [31:0]       digest_q [DIGEST_WORDS];
  logic [7:0]        blk_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              err_cmd_q;
  logic              err_to_q;
  logic              irq_en_q;

  logic [4:0]  idx;
  logic        bus_wr;
  logic        bus_rd;
  logic        ctrl_wr;
  logic        data_wr;
  logic        cmd_ok;
  logic        busy;
  logic [31:0] status;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign idx     = addr_i[7:3];
  assign bus_wr  = en_i && acct_ctrl_i && we_i;
  assign bus_rd  = en_i && acct_ctrl_i && !we_i;
  assign ctrl_wr = bus_wr && (idx == IDX_CTRL) && !reglk_ctrl_i[1];
  assign data_wr = bus_wr && (idx >= 5'd1) && (idx <= DATA_LAST) && !reglk_ctrl_i[3];
  assign cmd_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) && core_ready_i;
  assign busy    = (state_q == S_ISSUE) || (state_q == S_BUSY);
  assign status  = {16'h0, blk_cnt_q, 3'b0, err_to_q, err_cmd_q, busy,
                    (state_q == S_DONE), cmd_ok};
  assign unused_bits = ^{reglk_ctrl_i[7:5], addr_i[2:0], wdata_i};

  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_block
    assign core_block_o[32*g +: 32] = data_q[g];
  end

  always_comb begin
    rd_word = 32'h0;
    if (bus_rd) begin
      if (idx == IDX_CTRL)
        rd_word = {28'h0, irq_en_q, 3'b0};
      if (idx == IDX_STATUS && !reglk_ctrl_i[0])
        rd_word = status;
      for (int i = 0; i < BLOCK_WORDS; i++)
        if (idx == 5'(i + 1) && !reglk_ctrl_i[2])
          rd_word = data_q[i];
      for (int i = 0; i < DIGEST_WORDS; i++)
        if (idx == 5'(18 + i) && idx >= DIG_FIRST && idx <= DIG_LAST && !reglk_ctrl_i[4])
          rd_word = digest_q[i];
    end
    rdata_o       = '0;
    rdata_o[31:0] = rd_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      blk_cnt_q   <= 8'h0;
      to_cnt_q    <= '0;
      err_cmd_q   <= 1'b0;
      err_to_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      core_init_o <= 1'b0;
      core_next_o <= 1'b0;
      irq_o       <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++)  data_q[i]   <= 32'h0;
      for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= 32'h0;
    end else begin
      core_init_o <= 1'b0;
      core_next_o <= 1'b0;
      irq_o       <= 1'b0;
      if (ctrl_wr)
        irq_en_q <= wdata_i[3];

      // Clear wins over any start/next carried in the same write.
      if (ctrl_wr && wdata_i[2]) begin
        state_q   <= S_IDLE;
        blk_cnt_q <= 8'h0;
        to_cnt_q  <= '0;
        err_cmd_q <= 1'b0;
        err_to_q  <= 1'b0;
        for (int i = 0; i < DIGEST_WORDS; i++) digest_q[i] <= 32'h0;
      end else begin
        case (state_q)
          S_ISSUE: begin
            state_q  <= S_BUSY;
            to_cnt_q <= '0;
          end
          S_BUSY: begin
            if (core_digest_valid_i) begin
              for (int i = 0; i < DIGEST_WORDS; i++)
                digest_q[i] <= core_digest_i[32*i +: 32];
              blk_cnt_q <= blk_cnt_q + 8'd1;
              state_q   <= S_DONE;
              irq_o     <= irq_en_q;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
              err_to_q <= 1'b1;
              state_q  <= S_ERROR;
              irq_o    <= irq_en_q;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase

        if (ctrl_wr && (wdata_i[0] || wdata_i[1])) begin
          if (cmd_ok) begin
            state_q     <= S_ISSUE;
            core_init_o <= wdata_i[0];
            core_next_o <= !wdata_i[0];
          end else begin
            err_cmd_q <= 1'b1;
          end
        end

        // The core samples the block while it works, so it must not change underneath it.
        if (data_wr) begin
          if (busy)
            err_cmd_q <= 1'b1;
          else
            for (int i = 0; i < BLOCK_WORDS; i++)
              if (idx == 5'(i + 1))
                data_q[i] <= wdata_i[31:0];
        end
      end
    end
  end

endmodule
